// File: rtl/seven_segment_scanner_if.sv
// ============================================================================
// Module      : seven_segment_scanner_if
// Description : Value/decimal-point load channel (valid/ready) of the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_segment_scanner_if;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        value_valid;
    logic        value_ready;

    modport master (
        output value,
        output dp,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value,
        input  dp,
        input  value_valid,
        output value_ready
    );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scanner.sv
// ============================================================================
// Module      : seven_segment_scanner
// Description : 8-digit multiplexed seven-segment scanner with blanking gaps
//               and frame-synchronous (tear-free) value updates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scanner #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seven_segment_scanner_if.slave  load,
    input  wire logic [7:0]         digit_enable,
    output logic [3:0]              digit_code,
    input  wire logic [7:0]         dec_cathodes,
    output logic [7:0]              anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_start
);

    localparam int c_CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CW-1:0] c_SHOW_LAST  = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);

    localparam logic [0:0] c_PH_BLANK = 1'b0;
    localparam logic [0:0] c_PH_SHOW  = 1'b1;

    logic [0:0]      r_phase;
    logic [2:0]      r_idx;
    logic [c_CW-1:0] r_cnt;

    logic [0:0]      w_phase_nxt;
    logic [2:0]      w_idx_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_frame_end;

    logic [31:0]     r_disp_value;
    logic [7:0]      r_disp_dp;
    logic [31:0]     r_shadow_value;
    logic [7:0]      r_shadow_dp;
    logic            r_pending;

    logic            w_accept;
    logic            w_commit;
    logic            w_lit;
    logic            w_unused_dec7;

    // ------------------------------------------------------------------
    // Scan sequencer: BLANK -> SHOW per digit, index advances after SHOW
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= c_PH_BLANK;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + c_CW'(1);
        w_frame_end = 1'b0;
        if (r_phase == c_PH_BLANK) begin
            if (r_cnt == c_BLANK_LAST) begin
                w_phase_nxt = c_PH_SHOW;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (r_cnt == c_SHOW_LAST) begin
                w_phase_nxt = c_PH_BLANK;
                w_idx_nxt   = r_idx + 3'd1;
                w_cnt_nxt   = '0;
                w_frame_end = (r_idx == 3'd7);
            end
        end
    end

    // ------------------------------------------------------------------
    // Load channel: one-deep shadow, committed only at the frame boundary
    // ------------------------------------------------------------------
    assign w_accept         = load.value_valid && !r_pending;
    assign w_commit         = w_frame_end && r_pending;
    assign load.value_ready = ~r_pending;

    // accept and commit are mutually exclusive since they need opposite pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_value   <= 32'd0;
            r_disp_dp      <= 8'd0;
            r_shadow_value <= 32'd0;
            r_shadow_dp    <= 8'd0;
            r_pending      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_disp_value <= r_shadow_value;
                r_disp_dp    <= r_shadow_dp;
                r_pending    <= 1'b0;
            end
            if (w_accept) begin
                r_shadow_value <= load.value;
                r_shadow_dp    <= load.dp;
                r_pending      <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode straight from registered state
    // ------------------------------------------------------------------
    assign w_lit       = (r_phase == c_PH_SHOW) && digit_enable[r_idx];
    assign digit_code  = r_disp_value[{r_idx, 2'b00} +: 4];
    assign anodes      = w_lit ? ~(8'h01 << r_idx) : 8'hFF;
    assign cathodes    = w_lit ? {~r_disp_dp[r_idx], dec_cathodes[6:0]} : 8'hFF;
    assign frame_start = (r_phase == c_PH_SHOW) && (r_idx == 3'd0) && (r_cnt == '0);

    // decoder's own dp bit is replaced by display_dp
    assign w_unused_dec7 = dec_cathodes[7];

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// ============================================================================
// Module      : tb_seven_segment_scanner
// Description : Self-checking bench; two scanners (4/2 and 1/1 timing) share
//               stimulus and are compared against a cycle-position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] digit_enable;
    logic [7:0] dec_cathodes;

    logic [3:0] dc_a, dc_b;
    logic [7:0] an_a, an_b, cat_a, cat_b;
    logic       fs_a, fs_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seven_segment_scanner_if bus_a ();
    seven_segment_scanner_if bus_b ();

    seven_segment_scanner #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .load         (bus_a),
        .digit_enable (digit_enable),
        .digit_code   (dc_a),
        .dec_cathodes (dec_cathodes),
        .anodes       (an_a),
        .cathodes     (cat_a),
        .frame_start  (fs_a)
    );

    seven_segment_scanner #(.CLK_DIV(1), .BLANK_CYCLES(1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .load         (bus_b),
        .digit_enable (digit_enable),
        .digit_code   (dc_b),
        .dec_cathodes (dec_cathodes),
        .anodes       (an_b),
        .cathodes     (cat_b),
        .frame_start  (fs_b)
    );

    // Reference model: scan position follows from cycles since reset release
    int          m_cd [2] = '{4, 1};
    int          m_bc [2] = '{2, 1};
    int          m_t  [2];
    logic [31:0] m_disp   [2];
    logic [7:0]  m_ddp    [2];
    logic [31:0] m_shadow [2];
    logic [7:0]  m_sdp    [2];
    logic        m_pend   [2];

    logic        s_vld;
    logic [31:0] s_val;
    logic [7:0]  s_dp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k]      = 0;
            m_disp[k]   = 32'd0;
            m_ddp[k]    = 8'd0;
            m_shadow[k] = 32'd0;
            m_sdp[k]    = 8'd0;
            m_pend[k]   = 1'b0;
        end
    endtask

    task automatic get_pos(input int k, output int dig, output int off, output bit show);
        int per;
        int p;
        per  = m_cd[k] + m_bc[k];
        p    = m_t[k] % (8 * per);
        dig  = p / per;
        off  = p % per;
        show = (off >= m_bc[k]);
    endtask

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            bit com;
            int tn;
            tn  = m_t[k] + 1;
            acc = s_vld && !m_pend[k];
            com = ((tn % (8 * (m_cd[k] + m_bc[k]))) == 0) && m_pend[k];
            if (com) begin
                m_disp[k] = m_shadow[k];
                m_ddp[k]  = m_sdp[k];
                m_pend[k] = 1'b0;
            end
            if (acc) begin
                m_shadow[k] = s_val;
                m_sdp[k]    = s_dp;
                m_pend[k]   = 1'b1;
            end
            m_t[k] = tn;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int         dig, off;
            bit         show, lit;
            logic [7:0] e_an, e_cat;
            logic [3:0] e_dc;
            logic       e_fs;
            get_pos(k, dig, off, show);
            lit   = show && digit_enable[dig];
            e_an  = lit ? ~(8'h01 << dig) : 8'hFF;
            e_cat = lit ? {~m_ddp[k][dig], dec_cathodes[6:0]} : 8'hFF;
            e_dc  = 4'((m_disp[k] >> (4 * dig)) & 32'hF);
            e_fs  = show && (dig == 0) && (off == m_bc[k]);
            check_eq($sformatf("anodes%0d", k),      32'(k == 0 ? an_a  : an_b),  32'(e_an));
            check_eq($sformatf("cathodes%0d", k),    32'(k == 0 ? cat_a : cat_b), 32'(e_cat));
            check_eq($sformatf("digit_code%0d", k),  32'(k == 0 ? dc_a  : dc_b),  32'(e_dc));
            check_eq($sformatf("frame_start%0d", k), 32'(k == 0 ? fs_a  : fs_b),  32'(e_fs));
            check_eq($sformatf("value_ready%0d", k),
                     32'(k == 0 ? bus_a.value_ready : bus_b.value_ready), 32'(!m_pend[k]));
        end
    endtask

    task automatic step(input logic r, input logic [7:0] en, input logic v,
                        input logic [31:0] x, input logic [7:0] d);
        @(negedge clk);
        rst               = r;
        digit_enable      = en;
        dec_cathodes      = 8'($urandom);
        s_vld             = v;
        s_val             = x;
        s_dp              = d;
        bus_a.value_valid = v;
        bus_a.value       = x;
        bus_a.dp          = d;
        bus_b.value_valid = v;
        bus_b.value       = x;
        bus_b.dp          = d;
        if (r) model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        if (!r) model_tick();
    endtask

    initial begin
        int  guard;
        int  dig, off;
        bit  show;

        rst               = 1'b1;
        digit_enable      = 8'hFF;
        dec_cathodes      = 8'h00;
        s_vld             = 1'b0;
        s_val             = 32'd0;
        s_dp              = 8'd0;
        bus_a.value_valid = 1'b0;
        bus_a.value       = 32'd0;
        bus_a.dp          = 8'd0;
        bus_b.value_valid = 1'b0;
        bus_b.value       = 32'd0;
        bus_b.dp          = 8'd0;
        model_reset();

        repeat (3) step(1'b1, 8'hFF, 1'b0, 32'd0, 8'd0);

        // free-running scan with no load
        repeat (100) step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);

        // mid-frame load, then offers while pending, then a retry after commit
        step(1'b0, 8'hFF, 1'b1, 32'h76543210, 8'h01);
        repeat (5) step(1'b0, 8'hFF, 1'b1, 32'hDEADBEEF, 8'hFF);
        repeat (120) step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);
        step(1'b0, 8'hFF, 1'b1, 32'hFEDCBA98, 8'h80);
        repeat (100) step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);

        // alternate digits disabled
        repeat (100) step(1'b0, 8'hAA, 1'b0, 32'd0, 8'd0);

        // randomized traffic
        repeat (1500)
            step(1'b0, 8'($urandom), ($urandom_range(0, 7) == 0), $urandom, 8'($urandom));

        // reset during SHOW of digit 5 with a value pending
        guard = 0;
        get_pos(0, dig, off, show);
        while (!(dig == 0 && !m_pend[0]) && guard < 200) begin
            step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);
            get_pos(0, dig, off, show);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL wait_digit0 timed out");
        end
        step(1'b0, 8'hFF, 1'b1, 32'h13572468, 8'hF0);
        guard = 0;
        get_pos(0, dig, off, show);
        while (!(dig == 5 && show) && guard < 200) begin
            step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);
            get_pos(0, dig, off, show);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL wait_digit5 timed out");
        end
        check_eq("ready_before_rst", 32'(bus_a.value_ready), 32'd0);
        repeat (2) step(1'b1, 8'hFF, 1'b0, 32'd0, 8'd0);
        repeat (100) step(1'b0, 8'hFF, 1'b0, 32'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter: CLK_DIV, 100000, clock cycles each digit is lit (SHOW phase); SHALL be >= 1.
REQ-002 Parameter: BLANK_CYCLES, 1000, clock cycles all anodes are off between digits (BLANK phase); SHALL be >= 1.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: value  input  32  eight 4-bit digit codes; digit i = value[4i+3:4i].
REQ-006 Port: dp  input  8  decimal-point enables, bit i for digit i, 1 = lit.
REQ-007 Port: value_valid  input  1  producer offers value/dp.
REQ-008 Port: value_ready  output  1  scanner can accept value/dp.
REQ-009 Port: digit_enable  input  8  per-digit enable, 1 = digit may light; not frame-synchronised.
REQ-010 Port: digit_code  output  4  code of the current digit, to external hex decoder.
REQ-011 Port: dec_cathodes  input  8  active-low segment pattern returned by the external decoder; only bits 6:0 used.
REQ-012 Port: anodes  output  8  active-low digit selects.
REQ-013 Port: cathodes  output  8  active-low segments; bit 7 = decimal point, bits 6:0 = segments g..a.
REQ-014 Port: frame_start  output  1  one-cycle pulse on the first SHOW cycle of digit 0.

Function
REQ-015 SHALL hold state {phase (BLANK/SHOW), digit index 0..7, phase counter, display_value[31:0], display_dp[7:0], shadow_value, shadow_dp, pending}.
REQ-016 Phase counter SHALL count 0..N-1, N = BLANK_CYCLES in BLANK, CLK_DIV in SHOW; it clears to 0 on every phase change.
REQ-017 BLANK at count BLANK_CYCLES-1 SHALL go to SHOW, same digit index.
REQ-018 SHOW at count CLK_DIV-1 SHALL go to BLANK, digit index (i+1) mod 8 (7 wraps to 0).
REQ-019 Frame period SHALL be exactly 8*(CLK_DIV+BLANK_CYCLES) cycles.
REQ-020 digit_code SHALL equal display_value[4i+3:4i] in both phases (decoder settles during BLANK).
REQ-021 In SHOW with digit_enable[i]=1: anodes = all ones except bit i = 0; cathodes[6:0] = dec_cathodes[6:0]; cathodes[7] = ~display_dp[i].
REQ-022 In BLANK, or in SHOW with digit_enable[i]=0: anodes = 8'hFF, cathodes = 8'hFF.
REQ-023 anodes, cathodes, frame_start SHALL be decoded from registered state only (plus digit_enable, dec_cathodes); no added latency.
REQ-024 value_ready SHALL equal ~pending.
REQ-025 On value_valid && value_ready: shadow_value <= value, shadow_dp <= dp, pending <= 1; value_valid while not ready SHALL be ignored, no state change.
REQ-026 At the SHOW(digit 7) -> BLANK(digit 0) edge with pending=1: display_value <= shadow_value, display_dp <= shadow_dp, pending <= 0; displayed data never changes mid-frame.
REQ-027 A handshake on the commit edge itself (pending was 0) SHALL land in shadow and commit at the next frame boundary.
REQ-028 frame_start SHALL be 1 iff phase=SHOW, index=0, counter=0.

Reset
REQ-029 While rst=1, and immediately on its assertion mid-operation: phase=BLANK, index=0, counter=0, display/shadow value and dp = 0, pending=0.
REQ-030 Resulting outputs: anodes=8'hFF, cathodes=8'hFF, value_ready=1, digit_code=0, frame_start=0.
REQ-031 After rst deasserts, first SHOW of digit 0 SHALL begin BLANK_CYCLES cycles later; a pending value lost to reset SHALL not be displayed.

Verification (CLK_DIV=4, BLANK_CYCLES=2 unless stated)
REQ-032 Reset release, digit_enable=8'hFF, no load -> anodes 8'hFF for 2 cycles, then 8'hFE for 4, 8'hFF for 2, 8'hFD ..., frame_start every 48 cycles.
REQ-033 Load value=32'h76543210, dp=8'h01 mid-frame -> value_ready low until frame boundary; from next frame digit_code = i during digit i; cathodes[7]=0 only for digit 0.
REQ-034 Second value_valid while pending -> ignored, value_ready stays 0, first value displayed; retry after commit accepted.
REQ-035 digit_enable=8'b10101010 -> digits 0,2,4,6 SHOW slots show anodes=8'hFF, cathodes=8'hFF; odd digits light normally; timing unchanged.
REQ-036 Assert rst during SHOW of digit 5 with pending=1 -> same cycle anodes=8'hFF, cathodes=8'hFF, value_ready=1; after release display shows all zeros, scan restarts at digit 0.
REQ-037 CLK_DIV=1, BLANK_CYCLES=1 -> anodes alternate 8'hFF / single-zero every cycle, frame period 16 cycles, wrap 7->0 correct.
